// File: rtl/updown_pkg.sv
// Shared definitions for the parametrised up/down counter: mode encodings and
// the next-value decision used by the priority mux.
package updown_pkg;

   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   typedef enum logic [2:0] {
      HOLD,
      LOAD,
      STEP,
      CLAMP,
      WRAP,
      SAT
   } next_dec_e;

endpackage

// File: rtl/updown_next_calc.sv
// Combinational next-count calculation for an enabled cycle: step, limit
// crossing (wrap or saturate) and re-entry clamping when limits move.
module updown_next_calc
   import updown_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STEP_W = 4,
   parameter int MODE   = MODE_WRAP
) (
   input  logic [WIDTH-1:0]  count_i,
   input  logic [WIDTH-1:0]  lim_lo_i,
   input  logic [WIDTH-1:0]  lim_hi_i,
   input  logic [STEP_W-1:0] step_i,
   input  logic              up_down_i,
   output logic [WIDTH-1:0]  count_nxt_o,
   output logic              ovf_nxt_o,
   output logic              unf_nxt_o,
   output next_dec_e         dec_o
);

   // One guard bit above the wider operand so carries and borrows stay visible.
   localparam int  CW       = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;
   localparam bit  SAT_MODE = (MODE == MODE_SAT);

   logic [CW-1:0] cnt_ext;
   logic [CW-1:0] lo_ext;
   logic [CW-1:0] hi_ext;
   logic [CW-1:0] s_ext;
   logic [CW-1:0] sum;
   logic [CW-1:0] dif;
   logic          below;
   logic          above;
   logic          over;
   logic          under;

   always_comb begin
      s_ext   = (step_i == '0) ? CW'(1) : CW'(step_i);
      cnt_ext = CW'(count_i);
      lo_ext  = CW'(lim_lo_i);
      hi_ext  = CW'(lim_hi_i);
      sum     = cnt_ext + s_ext;
      dif     = cnt_ext - s_ext;
      below   = (count_i < lim_lo_i);
      above   = (count_i > lim_hi_i);
      over    = (sum > hi_ext);
      under   = (s_ext > cnt_ext) || (dif < lo_ext);
   end

   always_comb begin
      dec_o       = STEP;
      count_nxt_o = count_i;
      ovf_nxt_o   = 1'b0;
      unf_nxt_o   = 1'b0;
      if (below) begin
         dec_o       = CLAMP;
         count_nxt_o = lim_lo_i;
      end else if (above) begin
         dec_o       = CLAMP;
         count_nxt_o = lim_hi_i;
      end else if (up_down_i) begin
         if (over) begin
            ovf_nxt_o = 1'b1;
            if (SAT_MODE) begin
               dec_o       = SAT;
               count_nxt_o = lim_hi_i;
            end else begin
               dec_o       = WRAP;
               count_nxt_o = lim_lo_i;
            end
         end else begin
            count_nxt_o = sum[WIDTH-1:0];
         end
      end else begin
         if (under) begin
            unf_nxt_o = 1'b1;
            if (SAT_MODE) begin
               dec_o       = SAT;
               count_nxt_o = lim_lo_i;
            end else begin
               dec_o       = WRAP;
               count_nxt_o = lim_hi_i;
            end
         end else begin
            count_nxt_o = dif[WIDTH-1:0];
         end
      end
   end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with programmable limits, load, wrap/saturate
// behaviour, terminal flags and registered overflow/underflow pulses.
module updown_counter_param
   import updown_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter int               STEP_W  = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0,
   parameter int               MODE    = MODE_WRAP
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic              up_down_i,
   input  logic [STEP_W-1:0] step_i,
   input  logic              load_i,
   input  logic [WIDTH-1:0]  load_val_i,
   input  logic [WIDTH-1:0]  lim_lo_i,
   input  logic [WIDTH-1:0]  lim_hi_i,
   output logic [WIDTH-1:0]  count_o,
   output logic              at_lo_o,
   output logic              at_hi_o,
   output logic              ovf_o,
   output logic              unf_o,
   output logic              cfg_err_o
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic [WIDTH-1:0] load_clamped;
   logic [WIDTH-1:0] calc_nxt;
   logic             calc_ovf;
   logic             calc_unf;
   next_dec_e        calc_dec;
   next_dec_e        dec;
   logic             cfg_err;

   updown_next_calc #(
      .WIDTH  (WIDTH),
      .STEP_W (STEP_W),
      .MODE   (MODE)
   ) u_next_calc (
      .count_i     (count_q),
      .lim_lo_i    (lim_lo_i),
      .lim_hi_i    (lim_hi_i),
      .step_i      (step_i),
      .up_down_i   (up_down_i),
      .count_nxt_o (calc_nxt),
      .ovf_nxt_o   (calc_ovf),
      .unf_nxt_o   (calc_unf),
      .dec_o       (calc_dec)
   );

   always_comb begin
      cfg_err = (lim_lo_i > lim_hi_i);
      if (load_val_i < lim_lo_i) begin
         load_clamped = lim_lo_i;
      end else if (load_val_i > lim_hi_i) begin
         load_clamped = lim_hi_i;
      end else begin
         load_clamped = load_val_i;
      end
   end

   // Inverted limits freeze the counter until software fixes them.
   always_comb begin
      if (cfg_err) begin
         dec = HOLD;
      end else if (load_i) begin
         dec = LOAD;
      end else if (en_i) begin
         dec = calc_dec;
      end else begin
         dec = HOLD;
      end
   end

   always_comb begin
      count_d = count_q;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      unique case (dec)
         HOLD: count_d = count_q;
         LOAD: count_d = load_clamped;
         default: begin
            count_d = calc_nxt;
            ovf_d   = calc_ovf;
            unf_d   = calc_unf;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= RST_VAL;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign count_o   = count_q;
   assign ovf_o     = ovf_q;
   assign unf_o     = unf_q;
   assign at_lo_o   = (count_q == lim_lo_i);
   assign at_hi_o   = (count_q == lim_hi_i);
   assign cfg_err_o = cfg_err;

endmodule
